sga_input_conditioner: RTL and testbench

Front-end stage of the Snake Game Arcade that sits directly upstream of the top-level game core. It synchronizes and debounces the four raw direction buttons plus the start and pause keys, then produces three kinds of output for the control unit:
- clean levels;
- single-cycle press pulses;
- a latched direction command with a valid/ack handshake, so a press is never lost between game ticks.

---
 rtl/sga_input_conditioner_if.sv | 27 ++
 rtl/sga_input_conditioner.sv | 62 ++++++
 tb/tb_sga_input_conditioner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sga_input_conditioner_if.sv
// sga_input_conditioner_if: button/key bundle between the raw inputs and the game control unit
// Signals:
//   buttons_raw[3:0], start_raw, pause_raw  raw active-high keys ([3]=left [2]=right [1]=up [0]=down)
//   buttons[3:0], buttons_pulse[3:0]        debounced levels and one-cycle rise pulses
//   start_pulse, paused                     start rise pulse, pause toggle state
//   dir_valid, dir_code[1:0], dir_ack       latched direction command with consume strobe
// Modports: master = stimulus/control side, slave = conditioner side.
interface sga_input_conditioner_if;
    logic [3:0] buttons_raw;
    logic       start_raw;
    logic       pause_raw;
    logic [3:0] buttons;
    logic [3:0] buttons_pulse;
    logic       start_pulse;
    logic       paused;
    logic       dir_valid;
    logic [1:0] dir_code;
    logic       dir_ack;
    modport master (
        output buttons_raw, start_raw, pause_raw, dir_ack,
        input  buttons, buttons_pulse, start_pulse, paused, dir_valid, dir_code
    );
    modport slave (
        input  buttons_raw, start_raw, pause_raw, dir_ack,
        output buttons, buttons_pulse, start_pulse, paused, dir_valid, dir_code
    );
endinterface

// File: rtl/sga_input_conditioner.sv
// sga_input_conditioner: synchronize and debounce direction/start/pause keys, latch a direction command
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-high reset
//   bus    sga_input_conditioner_if.slave (raw keys in, clean levels/pulses/command out, dir_ack in)
module sga_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input logic                    clock,
    input logic                    reset,
    sga_input_conditioner_if.slave bus
);
    // Channel order: [3:0] buttons, [4] start, [5] pause.
    logic [5:0]            raw, s1, s2, stable, pulse;
    logic [5:0][CNT_W-1:0] cnt;
    logic                  paused, dir_valid;
    logic [1:0]            dir_code, code;
    assign raw  = {bus.pause_raw, bus.start_raw, bus.buttons_raw};
    // Left > right > up > down; only meaningful when some button pulsed.
    assign code = pulse[3] ? 2'd0 : pulse[2] ? 2'd1 : pulse[1] ? 2'd2 : 2'd3;
    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            stable    <= '0;
            pulse     <= '0;
            cnt       <= '0;
            paused    <= 1'b0;
            dir_valid <= 1'b0;
            dir_code  <= 2'd0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int c = 0; c < 6; c++) begin
                pulse[c] <= 1'b0;
                if (s2[c] == stable[c])
                    cnt[c] <= '0;
                else if (cnt[c] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[c] <= s2[c];
                    cnt[c]    <= '0;
                    pulse[c]  <= s2[c];
                end else
                    cnt[c] <= cnt[c] + 1'b1;
            end
            if (pulse[5])
                paused <= ~paused;
            // A press uses the pre-toggle paused and wins over a same-cycle ack.
            if (|pulse[3:0] && !paused) begin
                dir_valid <= 1'b1;
                dir_code  <= code;
            end else if (bus.dir_ack)
                dir_valid <= 1'b0;
        end
    end
    assign bus.buttons       = stable[3:0];
    assign bus.buttons_pulse = pulse[3:0];
    assign bus.start_pulse   = pulse[4];
    assign bus.paused        = paused;
    assign bus.dir_valid     = dir_valid;
    assign bus.dir_code      = dir_code;
endmodule

// File: tb/tb_sga_input_conditioner.sv
// tb_sga_input_conditioner: directed scoreboard bench for sga_input_conditioner with DEBOUNCE_CYCLES=4
module tb_sga_input_conditioner;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [1:0] exp_q[$];
    sga_input_conditioner_if ifc ();
    sga_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc.slave)
    );
    always #5 clock = ~clock;
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask
    task automatic pop_dir(input string tag);
        chk({tag, "_pending"}, 16'(exp_q.size() != 0), 16'd1);
        chk({tag, "_valid"}, 16'(ifc.dir_valid), 16'd1);
        if (exp_q.size() != 0)
            chk({tag, "_code"}, 16'(ifc.dir_code), 16'(exp_q.pop_front()));
    endtask
    function automatic logic [15:0] outs();
        return 16'({ifc.buttons, ifc.buttons_pulse, ifc.start_pulse, ifc.paused, ifc.dir_valid, ifc.dir_code});
    endfunction
    task automatic ack();
        ifc.dir_ack = 1'b1;
        tick(1);
        ifc.dir_ack = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        ifc.buttons_raw = 4'hf;
        ifc.start_raw = 1'b1;
        ifc.pause_raw = 1'b1;
        ifc.dir_ack = 1'b0;
        tick(3);
        reset = 1'b0;
        exp_q.push_back(2'd0);
        chk("reset_outs", outs(), 16'd0);
        tick(1);
        chk("post_reset_outs", outs(), 16'd0);
        tick(4);
        chk("held_not_yet", 16'(ifc.buttons), 16'h0);
        tick(1);
        chk("held_buttons", 16'(ifc.buttons), 16'hf);
        chk("held_bpulse", 16'(ifc.buttons_pulse), 16'hf);
        chk("held_start_pulse", 16'(ifc.start_pulse), 16'd1);
        chk("held_paused_pre", 16'(ifc.paused), 16'd0);
        tick(1);
        chk("held_paused", 16'(ifc.paused), 16'd1);
        chk("held_bpulse_once", 16'(ifc.buttons_pulse), 16'h0);
        chk("held_start_once", 16'(ifc.start_pulse), 16'd0);
        pop_dir("held_dir");
        ack();
        chk("ack_valid", 16'(ifc.dir_valid), 16'd0);
        chk("ack_code_hold", 16'(ifc.dir_code), 16'd0);
        ifc.buttons_raw = 4'h0;
        ifc.start_raw = 1'b0;
        ifc.pause_raw = 1'b0;
        tick(8);
        chk("release_buttons", 16'(ifc.buttons), 16'h0);
        chk("release_paused", 16'(ifc.paused), 16'd1);
        chk("release_valid", 16'(ifc.dir_valid), 16'd0);
        ifc.pause_raw = 1'b1;
        tick(7);
        chk("unpause", 16'(ifc.paused), 16'd0);
        ifc.pause_raw = 1'b0;
        tick(8);
        ifc.buttons_raw = 4'b0100;
        tick(3);
        ifc.buttons_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_outs", outs(), 16'd0);
        end
        ifc.buttons_raw = 4'b0100;
        exp_q.push_back(2'd1);
        tick(5);
        chk("right_not_yet", 16'(ifc.buttons), 16'h0);
        tick(1);
        chk("right_level", 16'(ifc.buttons), 16'b0100);
        chk("right_pulse", 16'(ifc.buttons_pulse), 16'b0100);
        chk("right_valid_pre", 16'(ifc.dir_valid), 16'd0);
        tick(1);
        chk("right_pulse_once", 16'(ifc.buttons_pulse), 16'h0);
        pop_dir("right_dir");
        tick(3);
        chk("right_no_repeat", 16'(ifc.buttons_pulse), 16'h0);
        ack();
        chk("right_ack", 16'(ifc.dir_valid), 16'd0);
        ifc.buttons_raw = 4'h0;
        tick(8);
        ifc.buttons_raw = 4'b1010;
        exp_q.push_back(2'd0);
        tick(6);
        chk("prio_pulse", 16'(ifc.buttons_pulse), 16'b1010);
        tick(1);
        pop_dir("prio_dir");
        ack();
        chk("prio_ack_valid", 16'(ifc.dir_valid), 16'd0);
        chk("prio_ack_code", 16'(ifc.dir_code), 16'd0);
        ifc.buttons_raw = 4'h0;
        tick(8);
        ifc.buttons_raw = 4'b1000;
        exp_q.push_back(2'd0);
        tick(7);
        pop_dir("pend_left");
        ifc.buttons_raw = 4'b1001;
        exp_q.push_back(2'd3);
        tick(6);
        chk("down_pulse", 16'(ifc.buttons_pulse), 16'b0001);
        ifc.dir_ack = 1'b1;
        tick(1);
        ifc.dir_ack = 1'b0;
        pop_dir("ack_press");
        ifc.buttons_raw = 4'h0;
        tick(8);
        ack();
        chk("ack_press_clear", 16'(ifc.dir_valid), 16'd0);
        ifc.pause_raw = 1'b1;
        tick(7);
        chk("pause_on", 16'(ifc.paused), 16'd1);
        ifc.pause_raw = 1'b0;
        tick(8);
        chk("pause_release", 16'(ifc.paused), 16'd1);
        ifc.buttons_raw = 4'b0100;
        tick(6);
        chk("paused_pulse", 16'(ifc.buttons_pulse), 16'b0100);
        tick(1);
        chk("paused_no_load", 16'(ifc.dir_valid), 16'd0);
        ifc.buttons_raw = 4'h0;
        tick(8);
        ifc.pause_raw = 1'b1;
        tick(7);
        chk("pause_off", 16'(ifc.paused), 16'd0);
        ifc.pause_raw = 1'b0;
        tick(8);
        ifc.buttons_raw = 4'b0010;
        exp_q.push_back(2'd2);
        tick(7);
        pop_dir("up_dir");
        ack();
        ifc.buttons_raw = 4'h0;
        tick(8);
        chk("pre_same_valid", 16'(ifc.dir_valid), 16'd0);
        ifc.buttons_raw = 4'b1000;
        ifc.pause_raw = 1'b1;
        exp_q.push_back(2'd0);
        tick(6);
        chk("same_pulse", 16'(ifc.buttons_pulse), 16'b1000);
        tick(1);
        chk("same_paused", 16'(ifc.paused), 16'd1);
        pop_dir("same_dir");
        ifc.buttons_raw = 4'h0;
        ifc.pause_raw = 1'b0;
        tick(8);
        ifc.start_raw = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        chk("mid_reset_outs", outs(), 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("mid_start_wait", 16'(ifc.start_pulse), 16'd0);
        end
        tick(1);
        chk("mid_start_pulse", 16'(ifc.start_pulse), 16'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mid_start_once", 16'(ifc.start_pulse), 16'd0);
        end
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
